// File: rtl/memory_access_stage_pkg.sv
// memory_access_stage_pkg: load/store type codes and FSM state encoding for the memory access stage.
package memory_access_stage_pkg;
  localparam logic [2:0] LOAD_NONE = 3'd0;
  localparam logic [2:0] LB = 3'd1;
  localparam logic [2:0] LH = 3'd2;
  localparam logic [2:0] LW = 3'd3;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [1:0] STORE_NONE = 2'd0;
  localparam logic [1:0] SB = 2'd1;
  localparam logic [1:0] SH = 2'd2;
  localparam logic [1:0] SW = 2'd3;
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  function automatic logic is_load(input logic [2:0] t);
    return t inside {LB, LH, LW, LBU, LHU};
  endfunction
endpackage

// File: rtl/memory_access_stage_load_store_aligner.sv
// load_store_aligner: store lane replication and byte enables, load lane extraction with sign/zero extension.
module load_store_aligner
  import memory_access_stage_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_type,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] load_data
);
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  always_comb begin
    rbyte = rdata[{lane, 3'b000} +: 8];
    rhalf = lane[1] ? rdata[31:16] : rdata[15:0];
    wdata = store_type == SB ? {4{store_data[7:0]}} :
            store_type == SH ? {2{store_data[15:0]}} : store_data;
    byte_en = store_type == SB ? 4'b0001 << lane :
              store_type == SH ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    load_data = load_type == LB  ? {{24{rbyte[7]}}, rbyte} :
                load_type == LBU ? {24'b0, rbyte} :
                load_type == LH  ? {{16{rhalf[15]}}, rhalf} :
                load_type == LHU ? {16'b0, rhalf} :
                load_type == LW  ? rdata : '0;
  end
endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: data-memory access via req/ready with registered write-back and stall request.
// Define MISALIGN_TRAP_EN to suppress misaligned halfword/word accesses and report them on MISALIGNED_ACCESS.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADD_WIDTH = 5,
  parameter int D_CACHE_LW_WIDTH = 3,
  parameter int D_CACHE_SW_WIDTH = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        CLEAR_MEMORY_STAGE,
  input  logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_IN,
  input  logic [DATA_WIDTH-1:0]       ALU_RESULT_IN,
  input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_IN,
  input  logic [D_CACHE_SW_WIDTH-1:0] DATA_CACHE_STORE_IN,
  input  logic [DATA_WIDTH-1:0]       DATA_CACHE_STORE_DATA,
  input  logic                        WRITE_BACK_MUX_SELECT_IN,
  input  logic                        RD_WRITE_ENABLE_IN,
  output logic                        MEM_REQ,
  output logic                        MEM_WE,
  output logic [ADDRESS_WIDTH-1:0]    MEM_ADDR,
  output logic [DATA_WIDTH-1:0]       MEM_WDATA,
  output logic [3:0]                  MEM_BYTE_EN,
  input  logic [DATA_WIDTH-1:0]       MEM_RDATA,
  input  logic                        MEM_READY,
  output logic                        STALL_REQUEST,
`ifdef MISALIGN_TRAP_EN
  output logic                        MISALIGNED_ACCESS,
`endif
  output logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_OUT,
  output logic [DATA_WIDTH-1:0]       WRITE_BACK_DATA,
  output logic                        RD_WRITE_ENABLE_OUT
);
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] alu_q, alu_d, sdata_q, sdata_d, wb_out_q, wb_out_d;
  logic [DATA_WIDTH-1:0] act_alu, act_sdata, wdata, load_data;
  logic [D_CACHE_LW_WIDTH-1:0] load_q, load_d, act_load;
  logic [D_CACHE_SW_WIDTH-1:0] store_q, store_d, act_store;
  logic [REG_ADD_WIDTH-1:0] rd_q, rd_d, act_rd, rd_out_q, rd_out_d;
  logic sel_q, sel_d, act_sel, we_q, we_d, act_we, we_out_q, we_out_d;
  logic discard_q, discard_d, in_idle, act_mem, mis, req, stall, bubble;
  logic [3:0] byte_en;
`ifdef MISALIGN_TRAP_EN
  logic mis_out_q, mis_out_d;
`endif

  load_store_aligner u_aligner (
    .lane       (act_alu[1:0]),
    .load_type  (act_load),
    .store_type (act_store),
    .store_data (act_sdata),
    .rdata      (MEM_RDATA),
    .wdata      (wdata),
    .byte_en    (byte_en),
    .load_data  (load_data)
  );

  // In IDLE the request comes straight from the inputs; in WAIT from the fields latched on entry.
  always_comb begin
    in_idle = state_q == ST_IDLE;
    act_alu = in_idle ? ALU_RESULT_IN : alu_q;
    act_sdata = in_idle ? DATA_CACHE_STORE_DATA : sdata_q;
    act_store = in_idle ? DATA_CACHE_STORE_IN : store_q;
    act_load = !in_idle ? load_q : DATA_CACHE_STORE_IN != STORE_NONE ? LOAD_NONE : DATA_CACHE_LOAD_IN;
    act_rd = in_idle ? RD_ADDRESS_IN : rd_q;
    act_we = in_idle ? RD_WRITE_ENABLE_IN : we_q;
    act_sel = in_idle ? WRITE_BACK_MUX_SELECT_IN : sel_q;
    act_mem = act_store != STORE_NONE || is_load(act_load);
`ifdef MISALIGN_TRAP_EN
    mis = in_idle && (((act_store == SH || act_load == LH || act_load == LHU) && act_alu[0]) ||
                      ((act_store == SW || act_load == LW) && act_alu[1:0] != 2'b00));
    mis_out_d = mis && !CLEAR_MEMORY_STAGE;
`else
    mis = 1'b0;
`endif
    req = in_idle ? act_mem && !CLEAR_MEMORY_STAGE && !mis : 1'b1;
    stall = req && !MEM_READY;
    state_d = stall ? ST_WAIT : ST_IDLE;
    discard_d = !in_idle && stall && (discard_q || CLEAR_MEMORY_STAGE);
    alu_d = act_alu;
    sdata_d = act_sdata;
    store_d = act_store;
    load_d = act_load;
    rd_d = act_rd;
    we_d = act_we;
    sel_d = act_sel;
    bubble = stall || CLEAR_MEMORY_STAGE || discard_q || mis;
    rd_out_d = bubble ? '0 : act_rd;
    we_out_d = bubble ? 1'b0 : act_we;
    wb_out_d = bubble ? '0 : act_sel ? load_data : act_alu;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      alu_q <= '0;
      sdata_q <= '0;
      store_q <= '0;
      load_q <= '0;
      rd_q <= '0;
      we_q <= 1'b0;
      sel_q <= 1'b0;
      discard_q <= 1'b0;
      rd_out_q <= '0;
      we_out_q <= 1'b0;
      wb_out_q <= '0;
    end else begin
      state_q <= state_d;
      alu_q <= alu_d;
      sdata_q <= sdata_d;
      store_q <= store_d;
      load_q <= load_d;
      rd_q <= rd_d;
      we_q <= we_d;
      sel_q <= sel_d;
      discard_q <= discard_d;
      rd_out_q <= rd_out_d;
      we_out_q <= we_out_d;
      wb_out_q <= wb_out_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge CLK) begin
    if (RST) mis_out_q <= 1'b0;
    else mis_out_q <= mis_out_d;
  end
  assign MISALIGNED_ACCESS = mis_out_q;
`endif

  assign MEM_REQ = req;
  assign MEM_WE = req && act_store != STORE_NONE;
  assign MEM_ADDR = {act_alu[ADDRESS_WIDTH-1:2], 2'b00};
  assign MEM_WDATA = wdata;
  assign MEM_BYTE_EN = byte_en;
  assign STALL_REQUEST = stall;
  assign RD_ADDRESS_OUT = rd_out_q;
  assign WRITE_BACK_DATA = wb_out_q;
  assign RD_WRITE_ENABLE_OUT = we_out_q;
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: scoreboard bench; expected write-back results are queued at drive time and popped after the edge.
module tb_memory_access_stage;
  logic clk = 1'b0;
  logic rst, clr, sel, we, rdy;
  logic [4:0] rd_in;
  logic [31:0] alu, sd, rdata;
  logic [2:0] ld;
  logic [1:0] st;
  logic mem_req, mem_we, stall, we_out;
  logic [31:0] mem_addr, mem_wdata, wb_out;
  logic [3:0] mem_be;
  logic [4:0] rd_out;
`ifdef MISALIGN_TRAP_EN
  logic mis_acc;
`endif
  typedef struct packed {logic [4:0] rd; logic we; logic [31:0] wb;} exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  memory_access_stage dut (
    .CLK                      (clk),
    .RST                      (rst),
    .CLEAR_MEMORY_STAGE       (clr),
    .RD_ADDRESS_IN            (rd_in),
    .ALU_RESULT_IN            (alu),
    .DATA_CACHE_LOAD_IN       (ld),
    .DATA_CACHE_STORE_IN      (st),
    .DATA_CACHE_STORE_DATA    (sd),
    .WRITE_BACK_MUX_SELECT_IN (sel),
    .RD_WRITE_ENABLE_IN       (we),
    .MEM_REQ                  (mem_req),
    .MEM_WE                   (mem_we),
    .MEM_ADDR                 (mem_addr),
    .MEM_WDATA                (mem_wdata),
    .MEM_BYTE_EN              (mem_be),
    .MEM_RDATA                (rdata),
    .MEM_READY                (rdy),
    .STALL_REQUEST            (stall),
`ifdef MISALIGN_TRAP_EN
    .MISALIGNED_ACCESS        (mis_acc),
`endif
    .RD_ADDRESS_OUT           (rd_out),
    .WRITE_BACK_DATA          (wb_out),
    .RD_WRITE_ENABLE_OUT      (we_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [2:0] l, input logic [1:0] s, input logic [31:0] d,
                       input logic sl, input logic [4:0] r, input logic w, input logic c, input logic y,
                       input logic [31:0] rd_word);
    alu = a;
    ld = l;
    st = s;
    sd = d;
    sel = sl;
    rd_in = r;
    we = w;
    clr = c;
    rdy = y;
    rdata = rd_word;
    #1;
  endtask

  task automatic tick(input logic er, input logic es, input logic [4:0] erd, input logic ewe, input logic [31:0] ewb);
    exp_t e;
    chk("mem_req", {31'b0, mem_req}, {31'b0, er});
    chk("stall", {31'b0, stall}, {31'b0, es});
    exp_q.push_back('{rd: erd, we: ewe, wb: ewb});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
    chk("we_out", {31'b0, we_out}, {31'b0, e.we});
    chk("wb_data", wb_out, e.wb);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    tick(0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    // SW zero-wait
    drive(32'h1004, 3'd0, 2'd3, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0);
    chk("sw_addr", mem_addr, 32'h1004);
    chk("sw_be", {28'b0, mem_be}, 32'hF);
    chk("sw_we", {31'b0, mem_we}, 1);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    tick(1, 0, 0, 0, 32'h1004);
    // LB with three wait cycles, inputs changing underneath
    drive(32'h1003, 3'd1, 2'd0, 0, 1, 5'd5, 1, 0, 0, 0);
    chk("lb_addr", mem_addr, 32'h1000);
    chk("lb_we", {31'b0, mem_we}, 0);
    chk("lb_be", {28'b0, mem_be}, 32'hF);
    tick(1, 1, 0, 0, 0);
    drive(32'hFFFFFFFF, 3'd0, 2'd0, 0, 0, 5'd9, 1, 0, 0, 0);
    chk("lb_hold_addr", mem_addr, 32'h1000);
    tick(1, 1, 0, 0, 0);
    drive(32'hFFFFFFFF, 3'd0, 2'd0, 0, 0, 5'd9, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    drive(32'hFFFFFFFF, 3'd0, 2'd0, 0, 0, 5'd9, 1, 0, 1, 32'h80FF0000);
    tick(1, 0, 5'd5, 1, 32'hFFFFFF80);
    // back-to-back zero-wait loads
    drive(32'h1002, 3'd5, 2'd0, 0, 1, 5'd6, 1, 0, 1, 32'h80011234);
    tick(1, 0, 5'd6, 1, 32'h00008001);
    drive(32'h1002, 3'd2, 2'd0, 0, 1, 5'd6, 1, 0, 1, 32'h80011234);
    tick(1, 0, 5'd6, 1, 32'hFFFF8001);
    drive(32'h1003, 3'd4, 2'd0, 0, 1, 5'd7, 1, 0, 1, 32'h80FF0000);
    tick(1, 0, 5'd7, 1, 32'h00000080);
    drive(32'h1008, 3'd3, 2'd0, 0, 1, 5'd8, 1, 0, 1, 32'h12345678);
    chk("lw_addr", mem_addr, 32'h1008);
    tick(1, 0, 5'd8, 1, 32'h12345678);
    // byte and half stores
    drive(32'h2001, 3'd0, 2'd1, 32'h000000AB, 0, 0, 0, 0, 1, 0);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    chk("sb_be", {28'b0, mem_be}, 32'h2);
    chk("sb_addr", mem_addr, 32'h2000);
    tick(1, 0, 0, 0, 32'h2001);
    drive(32'h2002, 3'd0, 2'd2, 32'h1234CDEF, 0, 0, 0, 0, 1, 0);
    chk("sh_wdata", mem_wdata, 32'hCDEFCDEF);
    chk("sh_be", {28'b0, mem_be}, 32'hC);
    tick(1, 0, 0, 0, 32'h2002);
    // load and store together: store wins
    drive(32'h3000, 3'd1, 2'd3, 32'h11223344, 0, 0, 0, 0, 1, 32'hFFFFFFFF);
    chk("both_we", {31'b0, mem_we}, 1);
    tick(1, 0, 0, 0, 32'h3000);
    // clear while waiting
    drive(32'h3000, 3'd3, 2'd0, 0, 1, 5'd7, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick(1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678);
    tick(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    // clear in idle suppresses the request
    drive(32'h3000, 3'd3, 2'd0, 0, 1, 5'd7, 1, 1, 1, 0);
    tick(0, 0, 0, 0, 0);
    // reserved load code and plain ALU ops
    drive(32'h66, 3'd6, 2'd0, 0, 0, 5'd3, 1, 0, 0, 0);
    tick(0, 0, 5'd3, 1, 32'h66);
    drive(32'h55, 3'd0, 2'd0, 0, 0, 5'd9, 1, 0, 0, 0);
    tick(0, 0, 5'd9, 1, 32'h55);
`ifdef MISALIGN_TRAP_EN
    drive(32'h1006, 3'd3, 2'd0, 0, 1, 5'd8, 1, 0, 1, 32'h12345678);
    tick(0, 0, 0, 0, 0);
    chk("mis_pulse", {31'b0, mis_acc}, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("mis_clear", {31'b0, mis_acc}, 0);
`else
    drive(32'h1006, 3'd3, 2'd0, 0, 1, 5'd8, 1, 0, 1, 32'hCAFEF00D);
    chk("mis_lw_addr", mem_addr, 32'h1004);
    tick(1, 0, 5'd8, 1, 32'hCAFEF00D);
    drive(32'h1003, 3'd2, 2'd0, 0, 1, 5'd2, 1, 0, 1, 32'h80011234);
    tick(1, 0, 5'd2, 1, 32'hFFFF8001);
`endif
    // reset in the middle of a wait
    drive(32'h77, 3'd0, 2'd0, 0, 0, 5'd3, 1, 0, 0, 0);
    tick(0, 0, 5'd3, 1, 32'h77);
    drive(32'h4000, 3'd3, 2'd0, 0, 1, 5'd5, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Pipeline stage directly downstream of the execution stage. It consumes the registered ALU result, the load/store controls, the store data and the rd controls.
- Performs the data-memory access through a request/ready handshake: byte-lane steering for stores, alignment and sign/zero extension for loads.
- Selects the write-back value and registers it for the write-back stage.
- Raises a stall request to the hazard unit while a memory access is outstanding.

Parameters:
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width (fixed 4 byte lanes)
- REG_ADD_WIDTH, 5, register address width
- D_CACHE_LW_WIDTH, 3, load-type code width
- D_CACHE_SW_WIDTH, 2, store-type code width

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- CLEAR_MEMORY_STAGE  in  1  flush: the current op produces a bubble
- RD_ADDRESS_IN  in  REG_ADD_WIDTH  destination register from execute
- ALU_RESULT_IN  in  DATA_WIDTH  ALU result / effective address
- DATA_CACHE_LOAD_IN  in  D_CACHE_LW_WIDTH  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6-7 treated as none
- DATA_CACHE_STORE_IN  in  D_CACHE_SW_WIDTH  0 none, 1 SB, 2 SH, 3 SW
- DATA_CACHE_STORE_DATA  in  DATA_WIDTH  raw rs2 value
- WRITE_BACK_MUX_SELECT_IN  in  1  1 = write back load data, 0 = write back ALU result
- RD_WRITE_ENABLE_IN  in  1  rd write enable
- MEM_REQ  out  1  access request
- MEM_WE  out  1  1 = write
- MEM_ADDR  out  ADDRESS_WIDTH  word-aligned address
- MEM_WDATA  out  DATA_WIDTH  lane-replicated store data
- MEM_BYTE_EN  out  4  byte enables
- MEM_RDATA  in  DATA_WIDTH  read word, valid when MEM_READY=1
- MEM_READY  in  1  access complete this cycle
- STALL_REQUEST  out  1  hold upstream stages
- RD_ADDRESS_OUT  out  REG_ADD_WIDTH  registered rd address
- WRITE_BACK_DATA  out  DATA_WIDTH  registered write-back value
- RD_WRITE_ENABLE_OUT  out  1  registered rd write enable

Behaviour:
- Reset: state IDLE; RD_ADDRESS_OUT, WRITE_BACK_DATA, RD_WRITE_ENABLE_OUT = 0; no request outstanding; MEM_REQ = 0.
- mem_op = (store != 0) or (load in 1..5). If both load and store are nonzero, the store wins and the load is ignored.
- FSM states:
  - IDLE, mem_op and not CLEAR: MEM_REQ = 1 combinationally from the inputs; request fields are latched. If MEM_READY = 1 in the same cycle, the access completes (zero-wait) and the state stays IDLE. Otherwise go to WAIT.
  - WAIT: MEM_REQ = 1, driven from the latched fields (stable until ready). On MEM_READY, complete and return to IDLE.
- STALL_REQUEST = MEM_REQ and not MEM_READY (combinational).
- Output register:
  - Loads a bubble (all zeros) on any cycle with STALL_REQUEST = 1, and on CLEAR.
  - Otherwise loads rd address / enable and WRITE_BACK_DATA = select ? load_data : ALU_RESULT.
  - Write-back latency: 1 cycle after completion.
- CLEAR during WAIT: the transaction still completes (no abort). The latched "discard" flag forces a bubble at completion. STALL_REQUEST holds until MEM_READY.
- RST during WAIT: return to IDLE immediately; MEM_REQ drops the next cycle. The memory side must tolerate the abandoned request.
- Address: MEM_ADDR = {addr[31:2], 2'b00}; lane = addr[1:0].
- Stores:
  - SB: WDATA = byte replicated x4; BE = 1 << lane.
  - SH: WDATA = half replicated x2; BE = addr[1] ? 1100 : 0011.
  - SW: BE = 1111.
  - MEM_WE = 1.
- Loads: MEM_WE = 0, BE = 1111.
  - LB/LBU: byte at lane, sign/zero-extended.
  - LH/LHU: half at addr[1], sign/zero-extended.
  - LW: full word.
- Non-mem op: passes straight to the output register. No request, no stall.
- Back-to-back mem ops: a new op is accepted in IDLE in the cycle after completion.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Misaligned accesses are halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - A misaligned access issues no MEM_REQ and writes back a bubble.
  - Adds output MISALIGNED_ACCESS (1 bit), registered and aligned with the output register, pulsed for one cycle.
- Undefined: low address bits beyond the lane select are ignored. A misaligned LW/SW accesses the aligned word; a misaligned LH takes the half at addr[1].

Decomposition:
- Shared package: load/store code constants (LOAD_NONE, LB, LH, LW, LBU, LHU; STORE_NONE, SB, SH, SW) and FSM state encodings.
- One natural sub-module, load_store_aligner (combinational): store lane steering and byte enables, load extraction and extension. The FSM and output register stay in the top.

Test Plan:
- SW, addr 0x0000_1004, data 0xDEADBEEF, MEM_READY high immediately:
  - MEM_ADDR = 0x1004, BE = 1111, WE = 1, STALL_REQUEST = 0.
  - Next cycle RD_WRITE_ENABLE_OUT = 0.
- LB, addr 0x1003, MEM_RDATA = 0x80FF_0000, ready after 3 cycles:
  - STALL_REQUEST high for 3 cycles, with bubbles during them.
  - Then WRITE_BACK_DATA = 0xFFFF_FF80, rd and enable as given.
- LHU, addr 0x1002, RDATA = 0x8001_1234: WRITE_BACK_DATA = 0x0000_8001.
- SB, addr 0x2001, data 0x0000_00AB: MEM_WDATA = 0xABABABAB, BE = 0010.
- CLEAR asserted in WAIT, then MEM_READY:
  - Access completes; output is a bubble (enable 0).
  - STALL_REQUEST drops with ready.
- ALU op (no load/store), ALU_RESULT = 0x55, select 0, enable 1:
  - No MEM_REQ.
  - Next cycle WRITE_BACK_DATA = 0x55, RD_WRITE_ENABLE_OUT = 1.
  - RST mid-WAIT returns all outputs to 0.
